// File: rtl/edge_event_arbiter.sv
// Per-channel edge detectors with one pending slot each, serialised onto a
// single valid/ready event port by round-robin arbitration.
module edge_event_arbiter #(
    parameter int         NUM_CH      = 4,
    parameter logic [1:0] TRIGGER     = 2'b11,
    parameter int         SYNC_STAGES = 2,
    parameter int         CH_W        = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] ctrl,
    input  logic [NUM_CH-1:0] ch_en,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [CH_W-1:0]   evt_ch,
    output logic              evt_rise,
    output logic [NUM_CH-1:0] pending,
    output logic [NUM_CH-1:0] overflow,
    input  logic              ovf_clr
);

    localparam int               SET_W      = $clog2(SYNC_STAGES + 2);
    localparam logic [SET_W-1:0] SETTLE_LEN = SET_W'(SYNC_STAGES + 1);

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_t;

    logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
    logic [NUM_CH-1:0] sync_d [SYNC_STAGES];
    logic [NUM_CH-1:0] prev_q, prev_d;
    logic [SET_W-1:0]  settle_q, settle_d;
    logic [NUM_CH-1:0] pend_q, pend_d;
    logic [NUM_CH-1:0] pend_rise_q, pend_rise_d;
    logic [NUM_CH-1:0] ovf_q, ovf_d;
    logic [CH_W-1:0]   rr_q, rr_d;
    out_state_t        state_q, state_d;
    logic [CH_W-1:0]   evt_ch_q, evt_ch_d;
    logic              evt_rise_q, evt_rise_d;

    logic [NUM_CH-1:0] lvl;
    logic              armed;
    logic [NUM_CH-1:0] rise_det;
    logic [NUM_CH-1:0] fall_det;
    logic [NUM_CH-1:0] req;
    logic              load;
    logic              gnt_valid;
    logic [CH_W-1:0]   gnt_idx;
    logic [CH_W-1:0]   scan_idx;
    logic [NUM_CH-1:0] gnt_oh;
    logic [NUM_CH-1:0] ovf_set;

    always_comb begin
        sync_d[0] = ctrl;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    assign lvl      = sync_q[SYNC_STAGES-1];
    assign prev_d   = lvl;
    assign armed    = (settle_q == '0);
    assign settle_d = armed ? '0 : settle_q - SET_W'(1);

    // Edges are only qualified once the settle window after reset has expired.
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_det
        assign rise_det[gi] = TRIGGER[0] & armed & ch_en[gi] &  lvl[gi] & ~prev_q[gi];
        assign fall_det[gi] = TRIGGER[1] & armed & ch_en[gi] & ~lvl[gi] &  prev_q[gi];
    end

    assign req  = pend_q & ch_en;
    assign load = (state_q == OUT_EMPTY) || evt_ready;

    // Scan from the farthest offset down so the nearest channel after rr wins.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        scan_idx  = '0;
        for (int k = NUM_CH; k >= 1; k--) begin
            scan_idx = CH_W'((int'(rr_q) + k) % NUM_CH);
            if (req[scan_idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = scan_idx;
            end
        end
    end

    always_comb begin
        gnt_oh = '0;
        if (load && gnt_valid) begin
            gnt_oh[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        pend_d      = pend_q;
        pend_rise_d = pend_rise_q;
        ovf_set     = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (!ch_en[c]) begin
                pend_d[c] = 1'b0;
            end else if (rise_det[c] || fall_det[c]) begin
                // A slot being granted this edge is free to take the new edge.
                if (pend_q[c] && !gnt_oh[c]) begin
                    ovf_set[c] = 1'b1;
                end else begin
                    pend_d[c]      = 1'b1;
                    pend_rise_d[c] = rise_det[c];
                end
            end else if (gnt_oh[c]) begin
                pend_d[c] = 1'b0;
            end
        end
    end

    assign ovf_d = (ovf_q & ~{NUM_CH{ovf_clr}}) | ovf_set;

    always_comb begin
        state_d    = state_q;
        evt_ch_d   = evt_ch_q;
        evt_rise_d = evt_rise_q;
        rr_d       = rr_q;
        if (load) begin
            if (gnt_valid) begin
                state_d    = OUT_FULL;
                evt_ch_d   = gnt_idx;
                evt_rise_d = pend_rise_q[gnt_idx];
                rr_d       = gnt_idx;
            end else begin
                state_d = OUT_EMPTY;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_d[i];
        end
        prev_q <= prev_d;
        if (!rst_n) begin
            settle_q    <= SETTLE_LEN;
            pend_q      <= '0;
            pend_rise_q <= '0;
            ovf_q       <= '0;
            rr_q        <= CH_W'(NUM_CH - 1);
            state_q     <= OUT_EMPTY;
            evt_ch_q    <= '0;
            evt_rise_q  <= 1'b0;
        end else begin
            settle_q    <= settle_d;
            pend_q      <= pend_d;
            pend_rise_q <= pend_rise_d;
            ovf_q       <= ovf_d;
            rr_q        <= rr_d;
            state_q     <= state_d;
            evt_ch_q    <= evt_ch_d;
            evt_rise_q  <= evt_rise_d;
        end
    end

    assign evt_valid = (state_q == OUT_FULL);
    assign evt_ch    = evt_ch_q;
    assign evt_rise  = evt_rise_q;
    assign pending   = pend_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed and random checks of edge_event_arbiter for three TRIGGER settings
// against a cycle-level behavioural model.
module tb_edge_event_arbiter;

    localparam int         NUM_CH      = 4;
    localparam int         SYNC_STAGES = 2;
    localparam int         NI          = 3;
    localparam logic [5:0] TRIGS       = {2'b00, 2'b01, 2'b11};

    logic          clk = 1'b0;
    logic          rst_n;
    logic          evt_ready;
    logic          ovf_clr;
    logic [3:0]    ctrl;
    logic [3:0]    ch_en;
    logic [NI-1:0] o_valid;
    logic [NI-1:0] o_rise;
    logic [1:0]    o_ch   [NI];
    logic [3:0]    o_pend [NI];
    logic [3:0]    o_ovf  [NI];

    int vec  = 0;
    int miss = 0;

    always #5 clk = ~clk;

    edge_event_arbiter #(.NUM_CH(NUM_CH), .TRIGGER(2'b11), .SYNC_STAGES(SYNC_STAGES)) dut_both (
        .clk(clk), .rst_n(rst_n), .ctrl(ctrl), .ch_en(ch_en),
        .evt_valid(o_valid[0]), .evt_ready(evt_ready), .evt_ch(o_ch[0]), .evt_rise(o_rise[0]),
        .pending(o_pend[0]), .overflow(o_ovf[0]), .ovf_clr(ovf_clr)
    );
    edge_event_arbiter #(.NUM_CH(NUM_CH), .TRIGGER(2'b01), .SYNC_STAGES(SYNC_STAGES)) dut_rise (
        .clk(clk), .rst_n(rst_n), .ctrl(ctrl), .ch_en(ch_en),
        .evt_valid(o_valid[1]), .evt_ready(evt_ready), .evt_ch(o_ch[1]), .evt_rise(o_rise[1]),
        .pending(o_pend[1]), .overflow(o_ovf[1]), .ovf_clr(ovf_clr)
    );
    edge_event_arbiter #(.NUM_CH(NUM_CH), .TRIGGER(2'b00), .SYNC_STAGES(SYNC_STAGES)) dut_none (
        .clk(clk), .rst_n(rst_n), .ctrl(ctrl), .ch_en(ch_en),
        .evt_valid(o_valid[2]), .evt_ready(evt_ready), .evt_ch(o_ch[2]), .evt_rise(o_rise[2]),
        .pending(o_pend[2]), .overflow(o_ovf[2]), .ovf_clr(ovf_clr)
    );

    // Reference model state, one copy per instance.
    bit         m_valid [NI];
    bit         m_known [NI];
    logic [1:0] m_ch    [NI];
    bit         m_evrise[NI];
    int         m_rr    [NI];
    logic [3:0] m_pend  [NI];
    logic [3:0] m_rise  [NI];
    logic [3:0] m_ovf   [NI];
    int         run_len = 0;
    logic [3:0] hist[$];

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        vec++;
        assert (got === exp) else begin
            miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Applied at each rising edge with the inputs that edge samples.
    function automatic void model_step();
        logic [3:0] lvl_old, lvl_new;
        logic [1:0] tr;
        bit         armed, load, up, dn, hit;
        int         g, c;
        if (hist.size() == SYNC_STAGES + 1) begin
            lvl_old = hist[0];
            lvl_new = hist[1];
            armed   = (run_len >= SYNC_STAGES + 1);
        end else begin
            lvl_old = '0;
            lvl_new = '0;
            armed   = 1'b0;
        end
        for (int i = 0; i < NI; i++) begin
            if (!rst_n) begin
                m_valid[i]  = 1'b0;
                m_known[i]  = 1'b1;
                m_ch[i]     = 2'd0;
                m_evrise[i] = 1'b0;
                m_rr[i]     = NUM_CH - 1;
                m_pend[i]   = '0;
                m_rise[i]   = '0;
                m_ovf[i]    = '0;
            end else begin
                tr   = TRIGS[2*i +: 2];
                load = !m_valid[i] || evt_ready;
                g    = -1;
                if (load) begin
                    for (int k = 1; k <= NUM_CH; k++) begin
                        c = (m_rr[i] + k) % NUM_CH;
                        if (g < 0 && m_pend[i][c] && ch_en[c]) g = c;
                    end
                    if (g >= 0) begin
                        m_valid[i]  = 1'b1;
                        m_known[i]  = 1'b1;
                        m_ch[i]     = 2'(g);
                        m_evrise[i] = m_rise[i][g];
                        m_rr[i]     = g;
                    end else begin
                        m_valid[i] = 1'b0;
                        m_known[i] = 1'b0;
                    end
                end
                if (ovf_clr) m_ovf[i] = '0;
                for (int ch = 0; ch < NUM_CH; ch++) begin
                    up  = lvl_new[ch] && !lvl_old[ch];
                    dn  = !lvl_new[ch] && lvl_old[ch];
                    hit = armed && ((up && tr[0]) || (dn && tr[1]));
                    if (!ch_en[ch]) begin
                        m_pend[i][ch] = 1'b0;
                    end else if (hit) begin
                        if (m_pend[i][ch] && ch != g) begin
                            m_ovf[i][ch] = 1'b1;
                        end else begin
                            m_pend[i][ch] = 1'b1;
                            m_rise[i][ch] = up;
                        end
                    end else if (ch == g) begin
                        m_pend[i][ch] = 1'b0;
                    end
                end
            end
        end
        if (!rst_n) run_len = 0;
        else if (run_len < 1000) run_len++;
        hist.push_back(ctrl);
        if (hist.size() > SYNC_STAGES + 1) void'(hist.pop_front());
    endfunction

    task automatic check_model();
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("model_valid%0d", i), 8'(o_valid[i]), 8'(m_valid[i]));
            chk($sformatf("model_pending%0d", i), 8'(o_pend[i]), 8'(m_pend[i]));
            chk($sformatf("model_overflow%0d", i), 8'(o_ovf[i]), 8'(m_ovf[i]));
            if (m_known[i]) begin
                chk($sformatf("model_ch_rise%0d", i), 8'({o_ch[i], o_rise[i]}), 8'({m_ch[i], m_evrise[i]}));
            end
        end
    endtask

    task automatic tick(input int n);
        for (int t = 0; t < n; t++) begin
            @(posedge clk);
            model_step();
            #1;
            check_model();
        end
    endtask

    initial begin
        logic [3:0] flip;
        rst_n = 1'b0; ctrl = 4'b1111; ch_en = 4'b1111; evt_ready = 1'b1; ovf_clr = 1'b0;
        tick(5);
        chk("rst_valid", 8'(o_valid[0]), 8'd0);
        chk("rst_pending", 8'(o_pend[0]), 8'd0);
        chk("rst_ch_rise", 8'({o_ch[0], o_rise[0]}), 8'd0);

        // Inputs high through reset release: nothing may fire.
        rst_n = 1'b1;
        for (int t = 0; t < 10; t++) begin
            tick(1);
            chk("hold_high_valid", 8'(o_valid[0]), 8'd0);
            chk("hold_high_pending", 8'(o_pend[0]), 8'd0);
        end

        // ch2 falling, then rising, then falling, with exact latency.
        ctrl = 4'b1011;
        tick(3);
        chk("fall_pend_both", 8'(o_pend[0]), 8'b0100);
        chk("fall_pend_riseonly", 8'(o_pend[1]), 8'd0);
        tick(1);
        chk("fall_valid_both", 8'(o_valid[0]), 8'd1);
        chk("fall_ch_rise", 8'({o_ch[0], o_rise[0]}), 8'({2'd2, 1'b0}));
        chk("fall_valid_riseonly", 8'(o_valid[1]), 8'd0);
        tick(2);
        ctrl = 4'b1111;
        tick(2);
        chk("lat_k1_valid", 8'(o_valid[0]), 8'd0);
        tick(1);
        chk("lat_k2_pending", 8'(o_pend[0]), 8'b0100);
        chk("lat_k2_valid", 8'(o_valid[0]), 8'd0);
        tick(1);
        chk("lat_k3_valid", 8'(o_valid[0]), 8'd1);
        chk("lat_k3_ch_rise", 8'({o_ch[0], o_rise[0]}), 8'({2'd2, 1'b1}));
        tick(1);
        chk("lat_k4_valid", 8'(o_valid[0]), 8'd0);
        ctrl = 4'b1011;
        tick(4);
        chk("fall2_ch_rise", 8'({o_ch[0], o_rise[0]}), 8'({2'd2, 1'b0}));
        tick(1);
        chk("fall2_done", 8'(o_valid[0]), 8'd0);

        // All channels together after a fresh reset: ch0..ch3 back to back.
        rst_n = 1'b0; ctrl = 4'b0000;
        tick(4);
        rst_n = 1'b1;
        tick(6);
        ctrl = 4'b1111;
        tick(3);
        chk("all_rise_pending", 8'(o_pend[0]), 8'b1111);
        for (int n = 0; n < 4; n++) begin
            tick(1);
            chk("all_rise_valid", 8'(o_valid[0]), 8'd1);
            chk("all_rise_ch", 8'({o_ch[0], o_rise[0]}), 8'({n[1:0], 1'b1}));
            chk("none_trig_valid", 8'(o_valid[2]), 8'd0);
        end
        tick(1);
        chk("all_rise_done", 8'(o_valid[0]), 8'd0);
        ctrl = 4'b0000;
        tick(3);
        for (int n = 0; n < 4; n++) begin
            tick(1);
            chk("all_fall_ch", 8'({o_ch[0], o_rise[0]}), 8'({n[1:0], 1'b0}));
            chk("all_fall_riseonly", 8'(o_valid[1]), 8'd0);
        end
        tick(1);
        chk("all_fall_done", 8'(o_valid[0]), 8'd0);

        // Held ch1 event, then a pending edge, then an overflowing edge.
        evt_ready = 1'b0; ctrl = 4'b0010;
        tick(4);
        chk("hold_ch_rise", 8'({o_ch[0], o_rise[0]}), 8'({2'd1, 1'b1}));
        ctrl = 4'b0000;
        tick(3);
        chk("hold_pending", 8'(o_pend[0]), 8'b0010);
        chk("hold_no_ovf", 8'(o_ovf[0]), 8'd0);
        ctrl = 4'b0010;
        tick(3);
        chk("hold_ovf", 8'(o_ovf[0]), 8'b0010);
        chk("hold_stable", 8'({o_valid[0], o_ch[0], o_rise[0]}), 8'({1'b1, 2'd1, 1'b1}));
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        chk("ovf_cleared", 8'(o_ovf[0]), 8'd0);
        evt_ready = 1'b1;
        tick(1);
        chk("kept_type", 8'({o_valid[0], o_ch[0], o_rise[0]}), 8'({1'b1, 2'd1, 1'b0}));
        chk("kept_type_pend", 8'(o_pend[0]), 8'd0);
        tick(1);
        chk("kept_type_done", 8'(o_valid[0]), 8'd0);

        // Disabling a channel drops its pending slot and its later edges.
        evt_ready = 1'b0; ctrl = 4'b1010;
        tick(4);
        chk("en_hold_ch3", 8'({o_ch[0], o_rise[0]}), 8'({2'd3, 1'b1}));
        ctrl = 4'b1011;
        tick(3);
        chk("en_pend0", 8'(o_pend[0]), 8'b0001);
        ch_en = 4'b1110;
        tick(1);
        chk("en_cleared", 8'(o_pend[0]), 8'd0);
        ctrl = 4'b1010;
        tick(3);
        ctrl = 4'b1011;
        tick(3);
        chk("en_ignored_pend", 8'(o_pend[0]), 8'd0);
        chk("en_ignored_ovf", 8'(o_ovf[0]), 8'd0);
        ch_en = 4'b1111; evt_ready = 1'b1;
        tick(1);
        chk("en_drain", 8'(o_valid[0]), 8'd0);
        tick(3);
        chk("en_nothing_more", 8'(o_valid[0]), 8'd0);

        // Reset with a held event and two pending slots, edges in settle window.
        evt_ready = 1'b0; ctrl = 4'b0011;
        tick(4);
        chk("pre_rst_ch", 8'({o_valid[0], o_ch[0], o_rise[0]}), 8'({1'b1, 2'd3, 1'b0}));
        ctrl = 4'b0101;
        tick(3);
        chk("pre_rst_pend", 8'(o_pend[0]), 8'b0110);
        rst_n = 1'b0; ctrl = 4'b1010;
        tick(1);
        chk("mid_rst_out", 8'({o_valid[0], o_ch[0], o_rise[0]}), 8'd0);
        chk("mid_rst_pend", 8'(o_pend[0]), 8'd0);
        chk("mid_rst_ovf", 8'(o_ovf[0]), 8'd0);
        tick(2);
        rst_n = 1'b1; evt_ready = 1'b1; ctrl = 4'b1111;
        for (int t = 0; t < 10; t++) begin
            tick(1);
            chk("settle_valid", 8'(o_valid[0]), 8'd0);
            chk("settle_pend", 8'(o_pend[0]), 8'd0);
        end

        // Random traffic against the model.
        for (int t = 0; t < 1500; t++) begin
            flip = '0;
            for (int c = 0; c < NUM_CH; c++) begin
                if ($urandom_range(0, 5) == 0) flip[c] = 1'b1;
                ch_en[c] = ($urandom_range(0, 19) != 0);
            end
            ctrl      = ctrl ^ flip;
            rst_n     = ($urandom_range(0, 149) != 0);
            evt_ready = ($urandom_range(0, 3) != 0);
            ovf_clr   = ($urandom_range(0, 24) == 0);
            tick(1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
